// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline stage chain (pipe_stage_chain, pipe_slot).
// Optional perf counters are enabled with the PIPE_STAGE_PERF_EN macro.
package pipe_pkg;

    // Widest counter the saturating helper supports.
    localparam int unsigned SAT_MAX_W = 64;

    // Bits needed to hold a stage count in 0..depth.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Increment that sticks at 2^w-1 instead of wrapping.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] cnt,
                                                     input int unsigned          w);
        logic [SAT_MAX_W-1:0] max_val;
        max_val = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
        return (cnt >= max_val) ? max_val : cnt + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline register stage: reset, then flush, then stall/hold, then load.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter bit               CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } pipe_slot_t;

    pipe_slot_t slot_q;

    // A flush outranks stall; with CLEAR_DATA=0 a bubble keeps the stale payload.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q <= '{valid: 1'b0, data: RESET_VAL};
        end else if (flush) begin
            slot_q.valid <= 1'b0;
            if (CLEAR_DATA) begin
                slot_q.data <= RESET_VAL;
            end
        end else if (!stall) begin
            slot_q <= '{valid: d_valid, data: d_data};
        end
    end

    assign q_valid = slot_q.valid;
    assign q_data  = slot_q.data;

endmodule

// File: rtl/pipe_stage_chain.sv
// Generic DEPTH-stage pipeline register segment with per-stage valid, stall hold,
// per-stage flush and occupancy. Define PIPE_STAGE_PERF_EN to add stall/flush counters.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      DEPTH      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter bit               CLEAR_DATA = 1'b1,
    parameter int unsigned      CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall_en,
    input  logic [DEPTH-1:0]               flush_en,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               out_data,
    output logic [occ_width(DEPTH)-1:0]    occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]               stall_cnt,
    output logic [CNT_W-1:0]               flush_cnt
`endif
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic             d_valid [DEPTH];
    logic [WIDTH-1:0] d_data  [DEPTH];
    logic             valid   [DEPTH];
    logic [WIDTH-1:0] data    [DEPTH];
    logic [OCC_W-1:0] occ_c;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        // Stage 0 is fed from upstream, every later stage from its predecessor.
        if (k == 0) begin : g_head
            assign d_valid[k] = in_valid;
            assign d_data[k]  = in_data;
        end else begin : g_body
            assign d_valid[k] = valid[k-1];
            assign d_data[k]  = data[k-1];
        end

        pipe_slot #(
            .WIDTH      (WIDTH),
            .RESET_VAL  (RESET_VAL),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .stall   (stall_en),
            .flush   (flush_en[k]),
            .d_valid (d_valid[k]),
            .d_data  (d_data[k]),
            .q_valid (valid[k]),
            .q_data  (data[k])
        );
    end

    // Popcount of the registered valid bits.
    always_comb begin
        occ_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ_c = occ_c + OCC_W'(valid[i]);
        end
    end

    assign occupancy = occ_c;
    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_en) begin
                stall_cnt_q <= CNT_W'(sat_inc(SAT_MAX_W'(stall_cnt_q), CNT_W));
            end
            if (|flush_en) begin
                flush_cnt_q <= CNT_W'(sat_inc(SAT_MAX_W'(flush_cnt_q), CNT_W));
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
